alu_control_mc: RTL and testbench

- Registered, parametrised ALU control stage for the ID/EX boundary of the MIPS pipeline.
- Decodes ALUOp, FunctionField and Double into an ALU operation code and a shift-select.
- Adds optional shift and logic ops (srl/sra/xor) and an optional divide.
- Sequences multi-cycle ops (mul, div) with a countdown that stalls upstream stages until the op completes.

---
 rtl/alu_control_mc.sv | 177 +++++++++++++++++
 tb/tb_alu_control_mc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_control_mc.sv
// alu_control_mc: registered ALU control for the ID/EX boundary.
// Ports: clk, rst_n, valid_in, ALUOp, FunctionField, Double, flush -> ALUCtrl, shift, valid_out, illegal, stall, mc_done.
module alu_control_mc #(
  parameter int CTRL_W     = 3,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int ENABLE_EXT = 1,
  parameter int ENABLE_DIV = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [2:0]        ALUOp,
  input  logic [5:0]        FunctionField,
  input  logic              Double,
  input  logic              flush,
  output logic [CTRL_W-1:0] ALUCtrl,
  output logic              shift,
  output logic              valid_out,
  output logic              illegal,
  output logic              stall,
  output logic              mc_done
);

  localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_N + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLT = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              shift_q, shift_d;
  logic              valid_q, valid_d;
  logic              ill_q, ill_d;
  logic              done1_q, done1_d;

  logic [3:0] dec_op;
  logic       dec_shift;
  logic       dec_ill;
  logic       dec_mc;
  int         dec_n;

  always_comb begin
    dec_op    = OP_ADD;
    dec_shift = 1'b0;
    dec_ill   = 1'b0;
    dec_mc    = 1'b0;
    dec_n     = 1;
    unique case (ALUOp)
      3'b000: begin
        if (!Double) begin
          unique case (FunctionField)
            6'b100000: dec_op = OP_ADD;
            6'b100010: dec_op = OP_SUB;
            6'b101010: dec_op = OP_SLT;
            6'b000000: begin
              dec_op    = OP_SLL;
              dec_shift = 1'b1;
            end
            6'b000010: begin
              if (ENABLE_EXT != 0) begin
                dec_op    = OP_SRL;
                dec_shift = 1'b1;
              end else dec_ill = 1'b1;
            end
            6'b000011: begin
              if (ENABLE_EXT != 0) begin
                dec_op    = OP_SRA;
                dec_shift = 1'b1;
              end else dec_ill = 1'b1;
            end
            6'b100110: begin
              if (ENABLE_EXT != 0) dec_op = OP_XOR;
              else dec_ill = 1'b1;
            end
            default: dec_ill = 1'b1;
          endcase
        end
      end
      3'b001: begin
        unique case (FunctionField)
          6'b000010: begin
            dec_op = OP_MUL;
            dec_mc = 1'b1;
            dec_n  = MUL_CYCLES;
          end
          6'b011010: begin
            if (ENABLE_DIV != 0) begin
              dec_op = OP_DIV;
              dec_mc = 1'b1;
              dec_n  = DIV_CYCLES;
            end else dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      3'b010, 3'b011, 3'b111: dec_op = OP_ADD;
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    shift_d = shift_q;
    ill_d   = ill_q;
    valid_d = 1'b0;
    done1_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      // last busy cycle: drop back to IDLE so the held op is taken next
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q - CNT_W'(1);
        valid_d = valid_q;
      end
    end else if (valid_in) begin
      ctrl_d  = CTRL_W'(dec_op);
      shift_d = dec_shift;
      ill_d   = dec_ill;
      valid_d = 1'b1;
      if (dec_mc) begin
        if (dec_n > 1) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(dec_n - 1);
        end else begin
          done1_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
      done1_q <= done1_d;
    end
  end

  assign ALUCtrl   = ctrl_q;
  assign shift     = shift_q;
  assign valid_out = valid_q;
  assign illegal   = ill_q;
  assign stall     = (state_q == BUSY);
  // single-cycle ops complete via done1_q; longer ones on the last count
  assign mc_done   = done1_q | ((state_q == BUSY) & (cnt_q == CNT_W'(1)));

endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: directed checks of alu_control_mc.
// Three builds share stimulus: default, no-ext/1-cycle mul, div-enabled.
module tb_alu_control_mc;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic       dbl;
  logic       flush;

  logic [2:0] a_ctrl, b_ctrl;
  logic [3:0] c_ctrl;
  logic a_sh, a_v, a_ill, a_st, a_dn;
  logic b_sh, b_v, b_ill, b_st, b_dn;
  logic c_sh, c_v, c_ill, c_st, c_dn;

  int n_tests = 0;
  int n_fail  = 0;

  alu_control_mc #(
    .CTRL_W(3), .MUL_CYCLES(4), .DIV_CYCLES(8),
    .ENABLE_EXT(1), .ENABLE_DIV(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .ALUOp(alu_op), .FunctionField(funct), .Double(dbl),
    .flush(flush), .ALUCtrl(a_ctrl), .shift(a_sh),
    .valid_out(a_v), .illegal(a_ill), .stall(a_st),
    .mc_done(a_dn)
  );

  alu_control_mc #(
    .CTRL_W(3), .MUL_CYCLES(1), .DIV_CYCLES(8),
    .ENABLE_EXT(0), .ENABLE_DIV(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .ALUOp(alu_op), .FunctionField(funct), .Double(dbl),
    .flush(flush), .ALUCtrl(b_ctrl), .shift(b_sh),
    .valid_out(b_v), .illegal(b_ill), .stall(b_st),
    .mc_done(b_dn)
  );

  alu_control_mc #(
    .CTRL_W(4), .MUL_CYCLES(2), .DIV_CYCLES(8),
    .ENABLE_EXT(1), .ENABLE_DIV(1)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .ALUOp(alu_op), .FunctionField(funct), .Double(dbl),
    .flush(flush), .ALUCtrl(c_ctrl), .shift(c_sh),
    .valid_out(c_v), .illegal(c_ill), .stall(c_st),
    .mc_done(c_dn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [5:0] f, input logic d);
    valid_in = v;
    alu_op   = op;
    funct    = f;
    dbl      = d;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b1, 3'b000, 6'b100010, 1'b0);
    #12;
    chk("rst_a", {29'd0, a_ctrl, a_sh, a_v, a_ill, a_st, a_dn}, 32'd0);
    chk("rst_c", {28'd0, c_ctrl, c_sh, c_v, c_ill, c_st, c_dn}, 32'd0);
    rst_n = 1'b1;
    tick();

    // sub
    drive(1'b1, 3'b000, 6'b100010, 1'b0);
    tick();
    chk("sub_ctrl", a_ctrl, 1);
    chk("sub_flags", {a_sh, a_v, a_st, a_ill}, 4'b0100);

    // sra with and without ext
    drive(1'b1, 3'b000, 6'b000011, 1'b0);
    tick();
    chk("sra_ctrl", a_ctrl, 6);
    chk("sra_sh_ill", {a_sh, a_ill}, 2'b10);
    chk("noext_ctrl", b_ctrl, 0);
    chk("noext_sh_ill", {b_sh, b_ill}, 2'b01);

    // Double forces add
    drive(1'b1, 3'b000, 6'b000000, 1'b1);
    tick();
    chk("dbl_ctrl", a_ctrl, 0);
    chk("dbl_sh", a_sh, 0);

    drive(1'b1, 3'b000, 6'b000000, 1'b0);
    tick();
    chk("sll", {a_ctrl, a_sh}, {3'd4, 1'b1});

    drive(1'b1, 3'b101, 6'b100010, 1'b0);
    tick();
    chk("op101", {a_ctrl, a_ill}, {3'd0, 1'b1});

    drive(1'b1, 3'b010, 6'b100010, 1'b0);
    tick();
    chk("op010", {a_ctrl, a_ill}, {3'd0, 1'b0});

    drive(1'b1, 3'b000, 6'b100110, 1'b0);
    tick();
    chk("xor", a_ctrl, 7);

    // no valid: hold op, valid_out low
    drive(1'b0, 3'b000, 6'b100010, 1'b0);
    tick();
    chk("hold", {a_ctrl, a_v}, {3'd7, 1'b0});

    // mul, 4 cycles on A, 1 cycle on B
    drive(1'b1, 3'b001, 6'b000010, 1'b0);
    tick();
    chk("mul1_a", {a_ctrl, a_v, a_st, a_dn}, {3'd3, 3'b110});
    chk("mul1_b", {b_ctrl, b_st, b_dn}, {3'd3, 2'b01});
    drive(1'b1, 3'b000, 6'b100010, 1'b0);
    tick();
    chk("mul2_a", {a_ctrl, a_v, a_st, a_dn}, {3'd3, 3'b110});
    chk("mul2_b_dn", b_dn, 0);
    tick();
    chk("mul3_a", {a_ctrl, a_v, a_st, a_dn}, {3'd3, 3'b111});
    tick();
    chk("mul4_a", {a_ctrl, a_st, a_dn}, {3'd3, 2'b00});
    tick();
    chk("mul5_a", {a_ctrl, a_v, a_st}, {3'd1, 2'b10});

    // div with flush
    drive(1'b1, 3'b001, 6'b011010, 1'b0);
    tick();
    chk("div1_c", {c_ctrl, c_v, c_st, c_dn}, {4'd8, 3'b110});
    chk("div1_a_ill", {a_ctrl, a_ill}, {3'd0, 1'b1});
    drive(1'b0, 3'b000, 6'b100000, 1'b0);
    tick();
    chk("div2_c", {c_st, c_dn}, 2'b10);
    tick();
    chk("div3_c", {c_st, c_dn}, 2'b10);
    flush = 1'b1;
    drive(1'b1, 3'b000, 6'b100010, 1'b0);
    tick();
    chk("div4_c", {c_ctrl, c_v, c_st, c_dn}, {4'd8, 3'b000});
    chk("flush_drop_a", {a_ctrl, a_v}, {3'd0, 1'b0});
    flush = 1'b0;
    drive(1'b1, 3'b000, 6'b100000, 1'b0);
    tick();
    chk("post_flush_c", {c_ctrl, c_v, c_st, c_ill}, {4'd0, 3'b100});

    // async reset mid-busy
    drive(1'b1, 3'b001, 6'b000010, 1'b0);
    tick();
    chk("busy_pre_rst", a_st, 1);
    drive(1'b0, 3'b000, 6'b100010, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {a_ctrl, a_v, a_st, a_dn}, 6'd0);
    rst_n = 1'b1;
    drive(1'b1, 3'b000, 6'b100010, 1'b0);
    @(posedge clk);
    #1;
    chk("after_rst", {a_ctrl, a_v, a_st}, {3'd1, 2'b10});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
